// File: rtl/alu_req_arbiter_if.sv
// rtl/alu_req_arbiter_if.sv - requester, result and ALU-side signal bundle for alu_req_arbiter
interface alu_req_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int FUN_WIDTH  = 4
);
    logic                      req0;
    logic                      req1;
    logic [DATA_WIDTH-1:0]     a0;
    logic [DATA_WIDTH-1:0]     a1;
    logic [DATA_WIDTH-1:0]     b0;
    logic [DATA_WIDTH-1:0]     b1;
    logic [FUN_WIDTH-1:0]      fun0;
    logic [FUN_WIDTH-1:0]      fun1;
    logic                      gnt0;
    logic                      gnt1;
    logic                      done0;
    logic                      done1;
    logic                      ack0;
    logic                      ack1;
    logic [2*DATA_WIDTH-1:0]   result;
    logic                      err;
    logic [DATA_WIDTH-1:0]     alu_a;
    logic [DATA_WIDTH-1:0]     alu_b;
    logic [FUN_WIDTH-1:0]      alu_fun;
    logic                      alu_en;
    logic                      clk_en;
    logic [2*DATA_WIDTH-1:0]   alu_out;
    logic                      alu_out_valid;
    logic                      busy;

    modport master (
        output req0, req1, a0, a1, b0, b1, fun0, fun1, ack0, ack1, alu_out, alu_out_valid,
        input  gnt0, gnt1, done0, done1, result, err, alu_a, alu_b, alu_fun, alu_en, clk_en, busy
    );

    modport slave (
        input  req0, req1, a0, a1, b0, b1, fun0, fun1, ack0, ack1, alu_out, alu_out_valid,
        output gnt0, gnt1, done0, done1, result, err, alu_a, alu_b, alu_fun, alu_en, clk_en, busy
    );
endinterface

// File: rtl/alu_req_arbiter.sv
// rtl/alu_req_arbiter.sv - round-robin two-requester arbiter for the shared gated-clock ALU
module alu_req_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int FUN_WIDTH  = 4,
    parameter int TIMEOUT    = 8
) (
    input  logic               clk,
    input  logic               rst,
    alu_req_arbiter_if.slave   bus
);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]    state;
    logic          rr_ptr;
    logic          winner;
    logic [CW-1:0] cnt;
    logic          pick1;
    logic          winner_ack;

    // requester 1 wins when it is alone, or when both request and the pointer favours it
    always_comb begin
        pick1      = bus.req1 && (!bus.req0 || rr_ptr);
        winner_ack = winner ? bus.ack1 : bus.ack0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= 1'b0;
            winner      <= 1'b0;
            cnt         <= '0;
            bus.gnt0    <= 1'b0;
            bus.gnt1    <= 1'b0;
            bus.done0   <= 1'b0;
            bus.done1   <= 1'b0;
            bus.result  <= {(2*DATA_WIDTH){1'b0}};
            bus.err     <= 1'b0;
            bus.alu_a   <= {DATA_WIDTH{1'b0}};
            bus.alu_b   <= {DATA_WIDTH{1'b0}};
            bus.alu_fun <= {FUN_WIDTH{1'b0}};
            bus.alu_en  <= 1'b0;
            bus.clk_en  <= 1'b0;
            bus.busy    <= 1'b0;
        end else begin
            bus.gnt0 <= 1'b0;
            bus.gnt1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        winner      <= pick1;
                        bus.gnt0    <= !pick1;
                        bus.gnt1    <= pick1;
                        bus.alu_a   <= pick1 ? bus.a1 : bus.a0;
                        bus.alu_b   <= pick1 ? bus.b1 : bus.b0;
                        bus.alu_fun <= pick1 ? bus.fun1 : bus.fun0;
                        bus.busy    <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.alu_en <= 1'b1;
                    bus.clk_en <= 1'b1;
                    cnt        <= '0;
                    state      <= WAIT;
                end
                WAIT: begin
                    bus.alu_en <= 1'b0;
                    cnt        <= cnt + 1'b1;
                    // a valid result on the final timeout cycle still counts as success
                    if (bus.alu_out_valid) begin
                        bus.result <= bus.alu_out;
                        bus.err    <= 1'b0;
                        bus.clk_en <= 1'b0;
                        bus.done0  <= !winner;
                        bus.done1  <= winner;
                        state      <= RESP;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        bus.result <= {(2*DATA_WIDTH){1'b0}};
                        bus.err    <= 1'b1;
                        bus.clk_en <= 1'b0;
                        bus.done0  <= !winner;
                        bus.done1  <= winner;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (winner_ack) begin
                        bus.done0 <= 1'b0;
                        bus.done1 <= 1'b0;
                        bus.busy  <= 1'b0;
                        rr_ptr    <= ~winner;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb/tb_alu_req_arbiter.sv - directed scoreboard bench for alu_req_arbiter
module tb_alu_req_arbiter;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    typedef struct packed {
        logic        who;
        logic [15:0] res;
        logic        err;
    } exp_t;

    exp_t exp_q[$];

    alu_req_arbiter_if #(.DATA_WIDTH(8), .FUN_WIDTH(4)) bus ();

    alu_req_arbiter #(.DATA_WIDTH(8), .FUN_WIDTH(4), .TIMEOUT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string tag, input bit ok);
        total++;
        if (!ok) begin
            bad++;
            $error("FAIL %s", tag);
        end
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic serve(input bit who, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] fun, input int vdelay, input logic [15:0] res,
                         output int gnt_ticks, output int done_ticks);
        bit   got;
        bit   cen_ok;
        exp_t e;
        if (who == 1'b0) begin
            bus.a0 = a; bus.b0 = b; bus.fun0 = fun; bus.req0 = 1'b1;
        end else begin
            bus.a1 = a; bus.b1 = b; bus.fun1 = fun; bus.req1 = 1'b1;
        end
        exp_q.push_back('{who: who, res: (vdelay == 0) ? 16'h0000 : res, err: (vdelay == 0)});

        gnt_ticks = 0;
        got = 1'b0;
        while (!got && gnt_ticks < 20) begin
            tick();
            gnt_ticks++;
            if (bus.gnt0 || bus.gnt1) got = 1'b1;
        end
        check("gnt_seen", got === 1'b1);
        check("gnt_who", {bus.gnt1, bus.gnt0} === (who ? 2'b10 : 2'b01));
        check("alu_a", bus.alu_a === a);
        check("alu_b", bus.alu_b === b);
        check("alu_fun", bus.alu_fun === fun);
        if (who == 1'b0) bus.req0 = 1'b0; else bus.req1 = 1'b0;

        tick();
        check("issue_alu_en", {bus.alu_en, bus.clk_en, bus.gnt0, bus.gnt1} === 4'b1100);

        done_ticks = 0;
        got = 1'b0;
        cen_ok = 1'b1;
        while (!got && done_ticks < 20) begin
            if (vdelay != 0 && done_ticks == vdelay) begin
                bus.alu_out_valid = 1'b1;
                bus.alu_out = res;
            end
            tick();
            bus.alu_out_valid = 1'b0;
            done_ticks++;
            if (bus.done0 || bus.done1) got = 1'b1;
            else if (!bus.clk_en || bus.alu_en) cen_ok = 1'b0;
        end
        check("done_seen", got === 1'b1);
        check("wait_clk_en", cen_ok === 1'b1);
        check("sb_nonempty", exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("done_who", {bus.done1, bus.done0} === (e.who ? 2'b10 : 2'b01));
            check("result", bus.result === e.res);
            check("err", bus.err === e.err);
        end
        check("resp_clk_en", bus.clk_en === 1'b0);
        check("operand_stable", {bus.alu_a, bus.alu_b, bus.alu_fun} === {a, b, fun});

        if (who == 1'b0) bus.ack1 = 1'b1; else bus.ack0 = 1'b1;
        bus.alu_out_valid = 1'b1;
        bus.alu_out = 16'h5A5A;
        tick();
        bus.ack0 = 1'b0; bus.ack1 = 1'b0; bus.alu_out_valid = 1'b0;
        check("done_hold", {bus.done1, bus.done0} === (who ? 2'b10 : 2'b01));
        check("result_hold", bus.result === ((vdelay == 0) ? 16'h0000 : res));

        if (who == 1'b0) bus.ack0 = 1'b1; else bus.ack1 = 1'b1;
        tick();
        bus.ack0 = 1'b0; bus.ack1 = 1'b0;
        check("done_clear", {bus.done1, bus.done0, bus.busy} === 3'b000);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int gt;
        int dt;
        total = 0;
        bad = 0;
        rst = 1'b1;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.a0 = '0; bus.a1 = '0; bus.b0 = '0; bus.b1 = '0;
        bus.fun0 = '0; bus.fun1 = '0;
        bus.ack0 = 1'b0; bus.ack1 = 1'b0;
        bus.alu_out = '0; bus.alu_out_valid = 1'b0;
        tick();
        tick();
        check("reset_ctrl", {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.err, bus.alu_en, bus.clk_en, bus.busy} === 8'h00);
        check("reset_data", {bus.result, bus.alu_a, bus.alu_b, bus.alu_fun} === 36'h0);

        bus.req0 = 1'b1; bus.req1 = 1'b1;
        tick();
        rst = 1'b0;
        serve(1'b0, 8'd1, 8'd2, 4'd0, 1, 16'h0003, gt, dt);
        check("t2_gnt0_latency", gt == 1);
        check("t2_idle_gap", {bus.gnt1, bus.busy} === 2'b00);
        serve(1'b1, 8'd7, 8'd2, 4'd1, 1, 16'h0005, gt, dt);
        check("t2_gnt1_after_gap", gt == 1);
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        serve(1'b0, 8'd4, 8'd4, 4'd2, 1, 16'h0010, gt, dt);
        serve(1'b1, 8'd9, 8'd9, 4'd3, 1, 16'h0051, gt, dt);

        serve(1'b0, 8'd12, 8'd3, 4'd0, 1, 16'h000F, gt, dt);
        check("t1_gnt_latency", gt == 1);
        check("t1_done_latency", dt == 2);

        serve(1'b1, 8'd5, 8'd6, 4'd4, 0, 16'h0000, gt, dt);
        check("t3_timeout_cycles", dt == 8);

        serve(1'b0, 8'hAB, 8'hCD, 4'd5, 7, 16'hABCD, gt, dt);
        check("t6_coincident_cycles", dt == 8);

        bus.a0 = 8'h11; bus.b0 = 8'h22; bus.fun0 = 4'd6; bus.req0 = 1'b1;
        tick();
        check("t5_gnt0", bus.gnt0 === 1'b1);
        bus.req0 = 1'b0;
        bus.req1 = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_reset_ctrl", {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.err, bus.alu_en, bus.clk_en, bus.busy} === 8'h00);
        check("t5_reset_data", {bus.result, bus.alu_a, bus.alu_b, bus.alu_fun} === 36'h0);
        serve(1'b1, 8'h33, 8'h44, 4'd7, 1, 16'h0077, gt, dt);
        check("t5_gnt1_after_reset", gt == 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
